msrr_seq: RTL and testbench

Command sequencer placed directly upstream of the team's 8-bit multi-function shift register (MSRR8). It accepts byte-level commands over a valid/ready handshake and expands each one into a cycle-by-cycle stream of `sel`/`sin` values that drive that register. The sequencer supports serial load and rotate-right. It reports completion with a one-cycle `done` pulse.

---
 rtl/msrr_seq_pkg.sv | 22 ++
 rtl/msrr_seq.sv | 139 +++++++++++++
 tb/tb_msrr_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/msrr_seq_pkg.sv
// msrr_seq_pkg: shared definitions for the MSRR8 command sequencer.
//   - command op codes (cmd_op)
//   - MSRR8 select encodings (sel)
//   - sequencer FSM state enum
package msrr_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_SHIN = 2'b10;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_ROR1 = 2'b01;
  localparam logic [1:0] SEL_ROR2 = 2'b10;
  localparam logic [1:0] SEL_SHR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/msrr_seq.sv
// msrr_seq: expands byte-level commands into per-cycle sel/sin streams
// for the 8-bit multi-function shift register MSRR8.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   cmd_valid  command presented
//   cmd_ready  sequencer idle, command will be accepted
//   cmd_op     00 HOLD, 01 ROTR, 10 SHIN, 11 reserved (acts as HOLD)
//   cmd_amt    step amount (SHIN: 0 means 8)
//   cmd_data   SHIN payload, sent LSB first
//   sel        MSRR8 select (00 hold, 01 ror1, 10 ror2, 11 shift-in)
//   sin        serial bit entering MSRR8 bit 7
//   busy       high in RUN and DONE
//   done       one-cycle completion pulse
//
// Build option: MSRR_SEQ_FASTROT_EN -- rotates use double steps (sel=10)
// where possible, halving ROTR latency. Default: single steps only.
module msrr_seq
  import msrr_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_amt,
  input  logic [7:0] cmd_data,
  output logic [1:0] sel,
  output logic       sin,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;     // steps remaining, including current
  logic [2:0] bidx_q,  bidx_d;    // index of current step
  logic [1:0] op_q,    op_d;
  logic [7:0] data_q,  data_d;
`ifdef MSRR_SEQ_FASTROT_EN
  logic [1:0] ndbl_q,  ndbl_d;    // number of leading double-rotate steps
`endif

  function automatic logic [3:0] step_count(input logic [1:0] op,
                                            input logic [2:0] amt);
    logic [3:0] n;
    n = '0;
    case (op)
      OP_SHIN: n = (amt == 3'd0) ? 4'd8 : {1'b0, amt};
`ifdef MSRR_SEQ_FASTROT_EN
      OP_ROTR: n = ({1'b0, amt} + 4'd1) >> 1;
`else
      OP_ROTR: n = {1'b0, amt};
`endif
      default: n = '0;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      op_q    <= OP_HOLD;
      data_q  <= '0;
`ifdef MSRR_SEQ_FASTROT_EN
      ndbl_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      op_q    <= op_d;
      data_q  <= data_d;
`ifdef MSRR_SEQ_FASTROT_EN
      ndbl_q  <= ndbl_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    op_d    = op_q;
    data_d  = data_q;
`ifdef MSRR_SEQ_FASTROT_EN
    ndbl_d  = ndbl_q;
`endif
    case (state_q)
      IDLE: begin
        // cmd_ready is 1 throughout IDLE, so cmd_valid alone accepts
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          bidx_d  = '0;
          cnt_d   = step_count(cmd_op, cmd_amt);
`ifdef MSRR_SEQ_FASTROT_EN
          ndbl_d  = cmd_amt[2:1];
`endif
          state_d = (step_count(cmd_op, cmd_amt) == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          bidx_d = bidx_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only
  always_comb begin
    sel       = SEL_HOLD;
    sin       = 1'b0;
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    if (state_q == RUN) begin
      if (op_q == OP_SHIN) begin
        sel = SEL_SHR;
        sin = data_q[bidx_q];
      end else begin
`ifdef MSRR_SEQ_FASTROT_EN
        sel = (bidx_q < {1'b0, ndbl_q}) ? SEL_ROR2 : SEL_ROR1;
`else
        sel = SEL_ROR1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_msrr_seq.sv
// tb_msrr_seq: directed test of msrr_seq with an MSRR8 reference register
// downstream. Expected values are hand-computed per vector; the
// MSRR_SEQ_FASTROT_EN macro selects the expected rotate latency.
module tb_msrr_seq;
  import msrr_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_amt;
  logic [7:0] cmd_data;
  logic [1:0] sel;
  logic       sin;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  msrr_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .sel       (sel),
    .sin       (sin),
    .busy      (busy),
    .done      (done)
  );

  // MSRR8 reference register
  logic [7:0] m;
  logic       mclr;
  always @(posedge clk) begin
    if (mclr) m <= 8'h00;
    else begin
      case (sel)
        2'b01:   m <= {m[0], m[7:1]};
        2'b10:   m <= {m[1:0], m[7:2]};
        2'b11:   m <= {sin, m[7:1]};
        default: m <= m;
      endcase
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command, record sel/sin per step cycle, return cycle of done.
  // Returns one cycle after done (back in IDLE).
  task automatic send(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data,
                      output int dcyc, output logic [31:0] sels, output logic [15:0] sins);
    sels = '0;
    sins = '0;
    dcyc = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    tick;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_amt   = ~amt;
    cmd_data  = ~data;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      if (c <= 16) begin
        sels[2*(c-1) +: 2] = sel;
        sins[c-1]          = sin;
      end
      tick;
    end
    if (dcyc == 0) check("done_seen", {31'b0, done}, 32'd1);
    check("done_busy", {31'b0, busy}, 32'd1);
    check("done_rdy", {31'b0, cmd_ready}, 32'd0);
    tick;
    check("idle_rdy", {31'b0, cmd_ready}, 32'd1);
    check("idle_done", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          d;
    logic [31:0] s;
    logic [15:0] b;
    logic [9:0]  bb_sel;
    logic [4:0]  bb_rdy;
    logic        seen;

    // Reset with a command pending
    rst = 1'b0; cmd_valid = 1'b1; cmd_op = OP_SHIN; cmd_amt = 3'd0;
    cmd_data = 8'hA5; mclr = 1'b1;
    tick; tick;
    check("rst_sel",  {30'b0, sel}, 32'd0);
    check("rst_sin",  {31'b0, sin}, 32'd0);
    check("rst_rdy",  {31'b0, cmd_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    cmd_valid = 1'b0; rst = 1'b1;
    tick;
    check("rst_noacc", {31'b0, busy}, 32'd0);
    mclr = 1'b0;

    // SHIN 8 bits of A5
    send(OP_SHIN, 3'd0, 8'hA5, d, s, b);
    check("shin_dcyc", d, 32'd9);
    check("shin_sel",  s, 32'h0000_FFFF);
    check("shin_sin",  {16'b0, b}, 32'h0000_00A5);
    check("shin_reg",  {24'b0, m}, 32'h0000_00A5);

    // ROTR 3 on A5
    send(OP_ROTR, 3'd3, 8'h00, d, s, b);
`ifdef MSRR_SEQ_FASTROT_EN
    check("rotr_dcyc", d, 32'd3);
    check("rotr_sel",  s, 32'h0000_0006);
`else
    check("rotr_dcyc", d, 32'd4);
    check("rotr_sel",  s, 32'h0000_0015);
`endif
    check("rotr_sin",  {16'b0, b}, 32'd0);
    check("rotr_reg",  {24'b0, m}, 32'h0000_00B4);

    // Zero-step commands
    send(OP_HOLD, 3'd5, 8'hFF, d, s, b);
    check("hold_dcyc", d, 32'd1);
    check("hold_reg",  {24'b0, m}, 32'h0000_00B4);
    send(OP_ROTR, 3'd0, 8'hFF, d, s, b);
    check("rot0_dcyc", d, 32'd1);
    check("rot0_reg",  {24'b0, m}, 32'h0000_00B4);
    send(2'b11, 3'd7, 8'hFF, d, s, b);
    check("rsv_dcyc",  d, 32'd1);
    check("rsv_reg",   {24'b0, m}, 32'h0000_00B4);

    // Back-to-back: SHIN 2 of 03, then ROTR 1 held valid throughout
    mclr = 1'b1; tick; mclr = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_SHIN; cmd_amt = 3'd2; cmd_data = 8'h03;
    tick;
    cmd_op = OP_ROTR; cmd_amt = 3'd1; cmd_data = 8'h00;
    bb_sel = {2'b01, 2'b00, 2'b00, 2'b11, 2'b11};
    bb_rdy = 5'b01000;
    for (int c = 1; c <= 5; c++) begin
      check("bb_sel", {30'b0, sel}, {30'b0, bb_sel[2*(c-1) +: 2]});
      check("bb_rdy", {31'b0, cmd_ready}, {31'b0, bb_rdy[c-1]});
      if (c == 3) check("bb_done", {31'b0, done}, 32'd1);
      if (c == 5) cmd_valid = 1'b0;
      tick;
    end
    check("bb_done2", {31'b0, done}, 32'd1);
    tick;
    check("bb_reg", {24'b0, m}, 32'h0000_0060);

    // Reset during SHIN after step 4
    mclr = 1'b1; tick; mclr = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_SHIN; cmd_amt = 3'd0; cmd_data = 8'hFF;
    tick;
    cmd_valid = 1'b0;
    tick; tick; tick;
    check("ab_step4", {30'b0, sel}, 32'd3);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("ab_sel",  {30'b0, sel}, 32'd0);
    check("ab_rdy",  {31'b0, cmd_ready}, 32'd1);
    check("ab_busy", {31'b0, busy}, 32'd0);
    seen = done;
    for (int c = 0; c < 10; c++) begin
      tick;
      seen = seen | done;
    end
    check("ab_nodone", {31'b0, seen}, 32'd0);
    check("ab_reg", {24'b0, m}, 32'h0000_00F0);
    send(OP_SHIN, 3'd1, 8'h01, d, s, b);
    check("ab_next_dcyc", d, 32'd2);
    check("ab_next_reg", {24'b0, m}, 32'h0000_00F8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
